spi_slave_fifo: RTL

//  SPI mode-0 target (responder) for the SoC SPI master: samples sclk/nss/mosi in the clk domain, drives miso.

---
 rtl/spi_slave_fifo.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_fifo.sv
// spi_slave_fifo: SPI mode-0 target with RX and TX byte FIFOs.
//   The SPI pins (sclk, nss, mosi) are asynchronous and are synchronized into clk.
//   Every received byte is pushed into the RX FIFO. Every transmitted byte is popped
//   from the TX FIFO. When the TX FIFO is empty at a byte load, TX_IDLE is sent instead.
// Ports:
//   clk, rst                  system clock, async active-high reset
//   sclk, nss, mosi, miso     SPI pins (CPOL=0, CPHA=0, MSB first)
//   tx_data/tx_valid/tx_ready host -> TX FIFO byte stream
//   rx_data/rx_valid/rx_ready RX FIFO -> host byte stream
//   rx_level, tx_level        FIFO occupancies
//   rx_ovf, tx_udf, frm_err   sticky error flags, cleared by clr_err
//   busy                      frame in progress
module spi_slave_fifo #(
    parameter int unsigned DEPTH   = 8,
    parameter logic [7:0]  TX_IDLE = 8'hFF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sclk,
    input  logic                    nss,
    input  logic                    mosi,
    output logic                    miso,
    input  logic [7:0]              tx_data,
    input  logic                    tx_valid,
    output logic                    tx_ready,
    output logic [7:0]              rx_data,
    output logic                    rx_valid,
    input  logic                    rx_ready,
    output logic [$clog2(DEPTH):0]  rx_level,
    output logic [$clog2(DEPTH):0]  tx_level,
    output logic                    rx_ovf,
    output logic                    tx_udf,
    output logic                    frm_err,
    input  logic                    clr_err,
    output logic                    busy
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_nxt;

    // [0] and [1] form the synchronizer. [2] is the edge-detect history.
    logic [2:0] sclk_q, nss_q;
    logic [1:0] mosi_q;
    logic       init_done, armed;
    logic       sclk_rise, sclk_fall, nss_rise, nss_fall, mosi_s;

    logic [2:0] bit_cnt;
    logic [7:0] tx_sh, rx_sh;
    logic       rx_push_q;
    logic       do_load, do_sample, do_shift, do_abort;

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    logic [AW:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic tx_empty, tx_full, tx_push, tx_pop;
    logic rx_empty, rx_full, rx_pop, rx_wr_en, ovf_set;

    // nss stage 2 is held high until the pin is seen high after reset.
    // This keeps a reset released mid-frame from looking like a fresh nss fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_q    <= '0;
            nss_q     <= '1;
            mosi_q    <= '0;
            init_done <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_q    <= {sclk_q[1:0], sclk};
            nss_q[0]  <= nss;
            nss_q[1]  <= armed ? nss_q[0] : 1'b1;
            nss_q[2]  <= nss_q[1];
            mosi_q    <= {mosi_q[0], mosi};
            init_done <= 1'b1;
            armed     <= armed | (init_done & nss_q[0]);
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign nss_rise  = nss_q[1] & ~nss_q[2];
    assign nss_fall  = ~nss_q[1] & nss_q[2];
    assign mosi_s    = mosi_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_sample = 1'b0;
        do_shift  = 1'b0;
        do_abort  = 1'b0;
        case (state)
            IDLE: begin
                if (nss_fall) begin
                    state_nxt = ACTIVE;
                    do_load   = 1'b1;
                end
            end
            ACTIVE: begin
                if (nss_rise) begin
                    state_nxt = IDLE;
                    do_abort  = 1'b1;
                end else if (sclk_rise) begin
                    do_sample = 1'b1;
                end else if (sclk_fall) begin
                    if (bit_cnt == 3'd0) do_load  = 1'b1;
                    else                 do_shift = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The completed byte is written into the RX FIFO one cycle after its last sample.
    // That write comes from rx_push_q and rx_sh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_push_q <= 1'b0;
            miso      <= 1'b0;
        end else begin
            rx_push_q <= 1'b0;
            miso      <= (state == ACTIVE) ? tx_sh[7] : 1'b0;
            if (do_load) begin
                bit_cnt <= '0;
                tx_sh   <= tx_empty ? TX_IDLE : tx_mem[tx_rd[AW-1:0]];
            end
            if (do_shift) tx_sh <= {tx_sh[6:0], 1'b0};
            if (do_sample) begin
                rx_sh     <= {rx_sh[6:0], mosi_s};
                bit_cnt   <= bit_cnt + 3'd1;
                rx_push_q <= (bit_cnt == 3'd7);
            end
            if (do_abort) begin
                bit_cnt <= '0;
                if (bit_cnt != 3'd0) rx_sh <= '0;
            end
        end
    end

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[AW] != tx_rd[AW]) && (tx_wr[AW-1:0] == tx_rd[AW-1:0]);
    assign tx_ready = ~tx_full;
    assign tx_push  = tx_valid & ~tx_full;
    assign tx_pop   = do_load & ~tx_empty;
    assign tx_level = tx_wr - tx_rd;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr[AW-1:0]] <= tx_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + PTR_ONE;
            if (tx_pop)  tx_rd <= tx_rd + PTR_ONE;
        end
    end

    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[AW] != rx_rd[AW]) && (rx_wr[AW-1:0] == rx_rd[AW-1:0]);
    assign rx_valid = ~rx_empty;
    assign rx_data  = rx_mem[rx_rd[AW-1:0]];
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_wr_en = rx_push_q & (~rx_full | rx_pop);
    assign ovf_set  = rx_push_q & rx_full & ~rx_pop;
    assign rx_level = rx_wr - rx_rd;

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem[rx_wr[AW-1:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_wr_en) rx_wr <= rx_wr + PTR_ONE;
            if (rx_pop)   rx_rd <= rx_rd + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ovf  <= 1'b0;
            tx_udf  <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            rx_ovf  <= ~clr_err & (rx_ovf | ovf_set);
            tx_udf  <= ~clr_err & (tx_udf | (do_load & tx_empty));
            frm_err <= ~clr_err & (frm_err | (do_abort & (bit_cnt != 3'd0)));
        end
    end

    assign busy = (state == ACTIVE);

endmodule
